// File: rtl/prio_enc_queue.sv
// Registered priority encoder queue: collects request pulses in a pending register
// and issues one encoded grant per accepted cycle, fixed-priority or round-robin.
module prio_enc_queue #(
  parameter int N  = 8,
  parameter int RR = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         any_pend,
  output logic         req_merged
);

  logic [N-1:0] r_pend;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_any;
  logic         r_merged;
  logic [W-1:0] r_ptr;

  logic [N-1:0] w_eff;
  logic         w_load;
  logic         w_found;
  logic [W-1:0] w_k;
  logic [N-1:0] w_kmask;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_nxt;
  logic         w_merge;

  assign w_eff  = r_pend | req_in;
  assign w_load = !r_valid || out_ready;

  // Search (ptr-1), (ptr-2), ... wrapping mod N; ptr stays 0 in fixed mode,
  // which makes the order N-1..0 (highest index wins).
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) - 1 - i;
      if (j < 0) j = j + N;
      if (!w_found && w_eff[j]) begin
        w_found = 1'b1;
        w_k     = W'(j);
      end
    end
  end

  always_comb begin
    w_kmask      = '0;
    w_kmask[w_k] = 1'b1;
    w_clr        = (w_load && w_found) ? w_kmask : '0;
    w_pend_nxt   = w_load ? (w_eff & ~w_clr) : w_eff;
    // A duplicate of the bit granted this same cycle is not a merge
    w_merge      = |(req_in & r_pend & ~w_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_any    <= 1'b0;
      r_merged <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_any    <= |w_pend_nxt;
      r_merged <= w_merge;
      if (w_load) begin
        r_valid <= w_found;
        if (w_found) begin
          r_idx    <= w_k;
          r_onehot <= w_kmask;
          if (RR != 0) r_ptr <= w_k;
        end
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign any_pend   = r_any;
  assign req_merged = r_merged;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Directed bench for prio_enc_queue: fixed N=8, round-robin N=4 and N=5 instances.
module tb_prio_enc_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  logic [7:0] req8;  logic rdy8;  logic v8;  logic [2:0] idx8;  logic [7:0] oh8;  logic ap8;  logic rm8;
  logic [3:0] req4;  logic rdy4;  logic v4;  logic [1:0] idx4;  logic [3:0] oh4;  logic ap4;  logic rm4;
  logic [4:0] req5;  logic rdy5;  logic v5;  logic [2:0] idx5;  logic [4:0] oh5;  logic ap5;  logic rm5;

  prio_enc_queue #(.N(8), .RR(0)) u_fix8 (
    .clk(clk), .rst(rst), .req_in(req8), .out_ready(rdy8), .out_valid(v8),
    .out_idx(idx8), .out_onehot(oh8), .any_pend(ap8), .req_merged(rm8));

  prio_enc_queue #(.N(4), .RR(1)) u_rr4 (
    .clk(clk), .rst(rst), .req_in(req4), .out_ready(rdy4), .out_valid(v4),
    .out_idx(idx4), .out_onehot(oh4), .any_pend(ap4), .req_merged(rm4));

  prio_enc_queue #(.N(5), .RR(1)) u_rr5 (
    .clk(clk), .rst(rst), .req_in(req5), .out_ready(rdy5), .out_valid(v5),
    .out_idx(idx5), .out_onehot(oh5), .any_pend(ap5), .req_merged(rm5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic v, input logic [2:0] idx,
                      input logic [7:0] oh, input logic ap, input logic rm);
    checks++;
    if ({v8, idx8, oh8, ap8, rm8} !== {v, idx, oh, ap, rm}) begin
      errors++;
      $display("FAIL %s: got v=%b idx=%0d oh=%h ap=%b rm=%b, want v=%b idx=%0d oh=%h ap=%b rm=%b",
               name, v8, idx8, oh8, ap8, rm8, v, idx, oh, ap, rm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req8 = '0; rdy8 = 1'b0; req4 = '0; rdy4 = 1'b0; req5 = '0; rdy5 = 1'b0;
    tick(); tick();
    checks++;
    if ({v8, idx8, oh8, ap8, rm8} !== 13'd0) begin
      errors++;
      $display("FAIL reset8: got %b want 0", {v8, idx8, oh8, ap8, rm8});
    end
    checks++;
    if ({v4, idx4, oh4, ap4, rm4, v5, idx5, oh5, ap5, rm5} !== 23'd0) begin
      errors++;
      $display("FAIL reset_rr: got %b want 0", {v4, idx4, oh4, ap4, rm4, v5, idx5, oh5, ap5, rm5});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fixed();
    rdy8 = 1'b1; req8 = 8'b0010_1001;
    tick(); req8 = '0;
    chk8("fixed_g5", 1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
    tick(); chk8("fixed_g3", 1'b1, 3'd3, 8'h08, 1'b1, 1'b0);
    tick(); chk8("fixed_g0", 1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
    tick(); checks++;
    if (v8 !== 1'b0) begin errors++; $display("FAIL fixed_idle: v=%b want 0", v8); end
  endtask

  task automatic test_backpressure();
    rdy8 = 1'b0; req8 = 8'h04;
    tick(); req8 = 8'h80;
    chk8("bp_g2", 1'b1, 3'd2, 8'h04, 1'b0, 1'b0);
    tick(); req8 = '0;
    chk8("bp_hold0", 1'b1, 3'd2, 8'h04, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8("bp_hold", 1'b1, 3'd2, 8'h04, 1'b1, 1'b0);
    end
    rdy8 = 1'b1;
    tick(); chk8("bp_g7", 1'b1, 3'd7, 8'h80, 1'b0, 1'b0);
    tick(); checks++;
    if (v8 !== 1'b0) begin errors++; $display("FAIL bp_idle: v=%b want 0", v8); end
  endtask

  task automatic test_merge();
    rdy8 = 1'b0; req8 = 8'h10;
    tick(); chk8("mg_t0", 1'b1, 3'd4, 8'h10, 1'b0, 1'b0);
    tick(); chk8("mg_t1", 1'b1, 3'd4, 8'h10, 1'b1, 1'b0);
    tick(); req8 = '0;
    chk8("mg_t2", 1'b1, 3'd4, 8'h10, 1'b1, 1'b1);
    tick(); chk8("mg_t3", 1'b1, 3'd4, 8'h10, 1'b1, 1'b0);
    rdy8 = 1'b1;
    tick(); chk8("mg_g2", 1'b1, 3'd4, 8'h10, 1'b0, 1'b0);
    tick(); checks++;
    if (v8 !== 1'b0) begin errors++; $display("FAIL mg_no_third: v=%b want 0", v8); end
  endtask

  task automatic test_rr4();
    logic [1:0] exp;
    rdy4 = 1'b1; req4 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = 2'(3 - (i % 4));
      checks++;
      if (v4 !== 1'b1 || idx4 !== exp || oh4 !== (4'b0001 << exp)) begin
        errors++;
        $display("FAIL rr4_%0d: v=%b idx=%0d oh=%b, want v=1 idx=%0d", i, v4, idx4, oh4, exp);
      end
    end
    req4 = '0; rdy4 = 1'b0;
  endtask

  task automatic test_rr5();
    logic [4:0] reqs [6] = '{5'b00100, 5'b10010, 5'b00000, 5'b00001, 5'b10010, 5'b00000};
    logic [2:0] expi [6] = '{3'd2, 3'd1, 3'd4, 3'd0, 3'd4, 3'd1};
    rdy5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req5 = reqs[i];
      tick();
      checks++;
      if (v5 !== 1'b1 || idx5 !== expi[i] || oh5 !== (5'b00001 << expi[i])) begin
        errors++;
        $display("FAIL rr5_%0d: v=%b idx=%0d oh=%b, want v=1 idx=%0d", i, v5, idx5, oh5, expi[i]);
      end
    end
    req5 = '0;
    tick(); checks++;
    if (v5 !== 1'b0) begin errors++; $display("FAIL rr5_idle: v=%b want 0", v5); end
  endtask

  task automatic test_async_reset();
    rdy8 = 1'b0; req8 = 8'h01;
    tick(); req8 = 8'h3C;
    tick(); req8 = '0;
    chk8("ar_pre", 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk8("ar_mid", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    tick(); rst = 1'b0; rdy8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8("ar_after", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_merge();
    test_rr4();
    test_rr5();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_enc_queue.md
Name: prio_enc_queue

Overview:
- Parametrised, registered successor to the team's 8-to-3 priority encoder.
- Accumulates request pulses from N sources in a pending register and issues one encoded grant at a time on a valid/ready output.
- Supports fixed-priority mode (highest index wins) and round-robin mode.
- Sits between interrupt/event sources and a single consumer such as a sequencer or interrupt controller.

Parameters:
- N, 8, number of request lines; legal range 2..256.
- RR, 0, priority mode: 0 = fixed, highest index wins; 1 = round-robin.
- W, $clog2(N), localparam, width of the encoded index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset.
- req_in  in  N  request pulses, one bit per source, sampled every cycle.
- out_ready  in  1  consumer accepts the current grant.
- out_valid  out  1  grant present.
- out_idx  out  W  encoded index of the granted source.
- out_onehot  out  N  one-hot form of out_idx.
- any_pend  out  1  pend register non-zero.
- req_merged  out  1  one-cycle pulse: an incoming request hit an already-pending bit.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst).
- Reset values: pend=0, out_valid=0, out_idx=0, out_onehot=0, any_pend=0, req_merged=0, rr_ptr=0. A reset mid-operation drops all pending requests and any held grant immediately, with no wait for a clock edge.
- eff = pend | req_in. This merge is combinational, so a request is eligible in the cycle it arrives.
- load = !out_valid || out_ready.
- When load is high and eff != 0:
  - Select index k from eff.
  - Register out_valid=1, out_idx=k, out_onehot=1<<k.
  - Next pend = eff & ~(1<<k).
  - In RR mode, next rr_ptr = k.
- When load is high and eff == 0: out_valid<=0, pend<=0. out_idx and out_onehot keep their last values; these are don't-care while out_valid=0.
- When load is low (out_valid && !out_ready):
  - Hold out_valid, out_idx and out_onehot stable.
  - Next pend = eff. Requests accumulate.
- Latency: a req_in pulse with the output stage idle produces out_valid on the next rising edge (1 cycle).
- Throughput: one grant per cycle while out_ready=1 and requests exist.
- Fixed mode: k = highest set index of eff, identical to the predecessor's ordering.
- RR mode search order: (rr_ptr-1) mod N, (rr_ptr-2) mod N, ..., down to rr_ptr. The search wraps modulo N, including for non-power-of-two N. With rr_ptr=0 the order is N-1..0, so after reset RR behaves like fixed priority. A source just granted is searched last on the next decision.
- Re-request of the currently held grant: the index is set in pend and is served again later. It is not merged into the held grant.
- req_merged: registered, high for one cycle when (req_in & pend) != 0.
  - Only bits pending at the start of the cycle count. The bit removed by a same-cycle load is excluded.
  - The duplicate is absorbed: each source has at most one outstanding request.
- any_pend: registered copy of (next pend != 0). It excludes the grant currently held in the output register.
- out_idx always < N. out_onehot always equals 1<<out_idx while out_valid=1.
- No combinational path from out_ready or req_in to any output.

Test Plan:
1. Fixed mode, N=8: req_in=8'b0010_1001 for 1 cycle, out_ready=1 -> out_idx sequence 5, 3, 0 on consecutive cycles, then out_valid=0; any_pend falls after the idx-3 grant.
2. Backpressure: out_ready=0, pulse req_in=8'h04 then 8'h80 -> out_idx=2 held stable for 4 cycles; on out_ready=1, next grant is 7; no req_merged pulse.
3. Merge: out_ready=0, req_in=8'h10 at t0, t1, t2 -> req_merged high at t2+1 only (first pulse goes to the output register, second to pend); after release exactly two grants of idx 4 and no third.
4. RR mode, N=4: hold req_in=4'b1111 continuously, out_ready=1 -> out_idx cycles 3, 2, 1, 0, 3, 2..., with each source granted once per 4 grants.
5. RR mode, N=5 (non-power-of-two): after a grant of idx 0, request {4, 1} -> next grant 4 (wrap), then 1; out_idx never equals 5, 6 or 7.
6. Async reset: assert rst mid-cycle while out_valid=1 and pend=8'h3C -> all outputs zero before the next edge; after release with no requests, out_valid stays 0.
